// File: rtl/cm_pkg.sv
// Shared types and constants for the cm_matrix_bank nibble substitution bank.
package cm_pkg;

  typedef enum logic {CM_INIT = 1'b0, CM_RUN = 1'b1} cm_state_e;
  typedef enum logic {CM_STATIC = 1'b0, CM_ROTATE = 1'b1} cm_mode_e;

  localparam int CM_NIB   = 4;
  localparam int CM_DEPTH = 16;

  // Increment modulo n, for index ranges that need not be a power of two.
  function automatic int cm_wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cm_lut16.sv
// One 16x4 flop LUT: synchronous write, lane-vectored combinational read port
// (a second read port for the chained stage when CM_CHAIN_EN is defined).
module cm_lut16
  import cm_pkg::*;
#(
  parameter int NPORT = 1
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [CM_NIB-1:0]             waddr_i,
  input  logic [CM_NIB-1:0]             wdata_i,
  input  logic [NPORT-1:0][CM_NIB-1:0]  raddr_i,
  output logic [NPORT-1:0][CM_NIB-1:0]  rdata_o
`ifdef CM_CHAIN_EN
  ,
  input  logic [NPORT-1:0][CM_NIB-1:0]  raddr2_i,
  output logic [NPORT-1:0][CM_NIB-1:0]  rdata2_o
`endif
);

  // Contents are not reset; the bank's INIT sweep loads identity.
  logic [CM_DEPTH-1:0][CM_NIB-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) rdata_o[p] = mem_q[raddr_i[p]];
  end

`ifdef CM_CHAIN_EN
  always_comb begin
    for (int p = 0; p < NPORT; p++) rdata2_o[p] = mem_q[raddr2_i[p]];
  end
`endif

endmodule

// File: rtl/cm_matrix_bank.sv
// Runtime-programmable bank of N_MAT nibble substitution matrices, LANES lanes wide.
// Optional CM_CHAIN_EN: second mapping stage through matrix (m_i+1) mod N_MAT.
module cm_matrix_bank
  import cm_pkg::*;
#(
  parameter int  LANES      = 2,
  parameter int  N_MAT      = 4,
  parameter int  ROT_PERIOD = 256,
  localparam int MAT_W      = $clog2(N_MAT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CM_NIB*LANES-1:0]   in_data_i,
  output logic                      out_valid_o,
  output logic [CM_NIB*LANES-1:0]   out_data_o,
  input  logic                      sel_mode_i,
  input  logic [MAT_W*LANES-1:0]    sel_mat_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [MAT_W-1:0]          cfg_mat_i,
  input  logic [CM_NIB-1:0]         cfg_addr_i,
  input  logic [CM_NIB-1:0]         cfg_data_i
);

  localparam int CNT_W = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;

  cm_state_e                 state_q, state_d;
  logic [CM_NIB-1:0]         init_cnt_q, init_cnt_d;
  logic [MAT_W-1:0]          rot_idx_q, rot_idx_d;
  logic [CNT_W-1:0]          rot_cnt_q, rot_cnt_d;
  logic                      run, acc, cfg_we;
  cm_mode_e                  mode;

  assign run         = (state_q == CM_RUN);
  assign in_ready_o  = run;
  assign cfg_ready_o = run;
  assign acc         = in_valid_i && run;
  assign cfg_we      = cfg_valid_i && run;
  assign mode        = cm_mode_e'(sel_mode_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CM_INIT;
      init_cnt_q <= '0;
      rot_idx_q  <= '0;
      rot_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rot_idx_q  <= rot_idx_d;
      rot_cnt_q  <= rot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rot_idx_d  = rot_idx_q;
    rot_cnt_d  = rot_cnt_q;
    case (state_q)
      CM_INIT: begin
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == 4'(CM_DEPTH - 1)) state_d = CM_RUN;
      end
      CM_RUN: begin
        // Step beat still looks up with the old rot_idx (m_i uses rot_idx_q).
        if (acc && mode == CM_ROTATE) begin
          if (rot_cnt_q == CNT_W'(ROT_PERIOD - 1)) begin
            rot_cnt_d = '0;
            rot_idx_d = MAT_W'(cm_wrap_inc(int'(rot_idx_q), N_MAT));
          end else begin
            rot_cnt_d = rot_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = CM_INIT;
    endcase
  end

  logic [LANES-1:0][MAT_W-1:0]              m;
  logic [LANES-1:0][CM_NIB-1:0]             nib, s1_res;
  logic [N_MAT-1:0][LANES-1:0][CM_NIB-1:0]  rd1;
  logic [CM_NIB-1:0]                        w_addr, w_data;

  assign nib    = in_data_i;
  assign w_addr = run ? cfg_addr_i : init_cnt_q;
  assign w_data = run ? cfg_data_i : init_cnt_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (mode == CM_ROTATE)
        m[i] = MAT_W'((int'(rot_idx_q) + i) % N_MAT);
      else if (int'(sel_mat_i[i*MAT_W +: MAT_W]) >= N_MAT)
        m[i] = MAT_W'(N_MAT - 1);
      else
        m[i] = sel_mat_i[i*MAT_W +: MAT_W];
      s1_res[i] = rd1[m[i]][i];
    end
  end

`ifdef CM_CHAIN_EN
  logic [N_MAT-1:0][LANES-1:0][CM_NIB-1:0]  rd2;
  logic [LANES-1:0][CM_NIB-1:0]             s1_q, s2_res;
  logic [LANES-1:0][MAT_W-1:0]              s1_m_q, m2;
  logic                                     s1_vld_q;
`endif

  // INIT sweeps identity into every matrix; cfg_mat >= N_MAT matches no matrix.
  for (genvar k = 0; k < N_MAT; k++) begin : g_mat
    logic we_k;
    assign we_k = !run || (cfg_we && int'(cfg_mat_i) == k);
    cm_lut16 #(.NPORT(LANES)) u_lut (
      .clk     (clk),
      .we_i    (we_k),
      .waddr_i (w_addr),
      .wdata_i (w_data),
      .raddr_i (nib),
      .rdata_o (rd1[k])
`ifdef CM_CHAIN_EN
      ,
      .raddr2_i(s1_q),
      .rdata2_o(rd2[k])
`endif
    );
  end

  logic                          out_valid_q;
  logic [LANES-1:0][CM_NIB-1:0]  out_data_q;

`ifdef CM_CHAIN_EN
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      m2[i]     = MAT_W'((int'(s1_m_q[i]) + 1) % N_MAT);
      s2_res[i] = rd2[m2[i]][i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_q        <= '0;
      s1_m_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_vld_q    <= acc;
      if (acc) begin
        s1_q   <= s1_res;
        s1_m_q <= m;
      end
      out_valid_q <= s1_vld_q;
      if (s1_vld_q) out_data_q <= s2_res;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= acc;
      if (acc) out_data_q <= s1_res;
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_cm_matrix_bank.sv
// Randomized self-checking bench for cm_matrix_bank (default single-stage build).
module tb_cm_matrix_bank;
  localparam int LANES = 2, N_MAT = 3, ROT_PERIOD = 4;
  localparam int MAT_W = $clog2(N_MAT);
  localparam int DW = 4 * LANES;
  localparam int SW = MAT_W * LANES;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, sel_mode = 1'b0, cfg_valid = 1'b0, cfg_ready;
  logic [DW-1:0] in_data = '0, out_data;
  logic [SW-1:0] sel_mat = '0;
  logic [MAT_W-1:0] cfg_mat = '0;
  logic [3:0] cfg_addr = '0, cfg_data = '0;

  int checks = 0, failures = 0;

  // Reference model: LUT contents, count of accepted ROTATE beats, expected output.
  int lut [N_MAT][16];
  int rot_beats;
  logic [DW-1:0] exp_out;

  always #5 clk = ~clk;

  cm_matrix_bank #(.LANES(LANES), .N_MAT(N_MAT), .ROT_PERIOD(ROT_PERIOD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_data_o(out_data),
    .sel_mode_i(sel_mode), .sel_mat_i(sel_mat),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_mat_i(cfg_mat), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N_MAT; k++)
      for (int a = 0; a < 16; a++) lut[k][a] = a;
    rot_beats = 0;
    exp_out = '0;
  endfunction

  function automatic int pick(input int lane, input bit mode, input logic [SW-1:0] sel);
    logic [SW-1:0] s;
    int v;
    if (mode) return ((rot_beats / ROT_PERIOD) + lane) % N_MAT;
    s = sel >> (lane * MAT_W);
    v = int'(s[MAT_W-1:0]);
    return (v >= N_MAT) ? N_MAT - 1 : v;
  endfunction

  // One RUN-state clock: drive, predict from the model (lookup before write), advance.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit mode,
                       input logic [SW-1:0] sel, input bit cv, input int cm,
                       input int ca, input int cd, output bit exp_v);
    in_valid = iv; in_data = d; sel_mode = mode; sel_mat = sel;
    cfg_valid = cv; cfg_mat = MAT_W'(cm); cfg_addr = 4'(ca); cfg_data = 4'(cd);
    exp_v = iv;
    if (iv) begin
      for (int i = 0; i < LANES; i++) begin
        logic [DW-1:0] sh;
        sh = d >> (4 * i);
        exp_out[i*4 +: 4] = 4'(lut[pick(i, mode, sel)][int'(sh[3:0])]);
      end
      if (mode) rot_beats++;
    end
    if (cv && cm < N_MAT) lut[cm][ca] = cd;
    step();
    in_valid = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic reset_and_init(output int cyc);
    in_valid = 1'b0; cfg_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc, early;
    bit ev;
    cfg_valid = 1'b1; cfg_mat = 2'd2; cfg_addr = 4'd0; cfg_data = 4'd7;
    in_valid = 1'b1; in_data = 8'hFF; sel_mode = 1'b0; sel_mat = '0;
    rst_n = 1'b0;
    step(); step();
    model_reset();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    rst_n = 1'b1;
    cyc = 0; early = 0;
    while (!cfg_ready && cyc < 40) begin
      step();
      cyc++;
      if (out_valid !== 1'b0) early++;
    end
    checks++; if (cyc != 16) begin failures++; $display("FAIL init_cycles got=%0d exp=16", cyc); end
    checks++; if (early != 0) begin failures++; $display("FAIL init_out_valid got=%0d exp=0", early); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL run_in_ready got=%b exp=1", in_ready); end
    // Held cfg write and held beat both accepted on the first RUN edge.
    cycle(1, 8'hFF, 0, '0, 1, 2, 0, 7, ev);
    checks++; if (out_valid !== ev || out_data !== exp_out) begin failures++; $display("FAIL first_run_beat got=%b/%h exp=%b/%h", out_valid, out_data, ev, exp_out); end
    cycle(1, 8'h00, 0, 4'b1010, 0, 0, 0, 0, ev);
    checks++; if (out_data !== 8'h77) begin failures++; $display("FAIL pending_cfg_write got=%h exp=77", out_data); end
  endtask

  task automatic test_identity();
    bit ev;
    cycle(1, 8'hA5, 0, '0, 0, 0, 0, 0, ev);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin failures++; $display("FAIL identity got=%b/%h exp=1/a5", out_valid, out_data); end
    cycle(0, 8'h3C, 0, '0, 0, 0, 0, 0, ev);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin failures++; $display("FAIL idle_hold got=%b/%h exp=0/a5", out_valid, out_data); end
  endtask

  task automatic test_cfg_write();
    bit ev;
    cycle(0, '0, 0, '0, 1, 1, 3, 12, ev);
    cycle(1, 8'h33, 0, 4'b0001, 0, 0, 0, 0, ev);
    checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL cfg_write_lookup got=%h exp=3c", out_data); end
  endtask

  task automatic test_clamp();
    bit ev;
    logic [DW-1:0] d;
    for (int a = 0; a < 16; a++) cycle(0, '0, 0, '0, 1, 2, a, $urandom_range(0, 15), ev);
    // Out-of-range target is accepted and discarded.
    for (int a = 0; a < 16; a++) cycle(0, '0, 0, '0, 1, 3, a, 15 - a, ev);
    for (int n = 0; n < 8; n++) begin
      d = DW'($urandom);
      cycle(1, d, 0, 4'b0111, 0, 0, 0, 0, ev);
      checks++; if (out_data !== exp_out) begin failures++; $display("FAIL clamp_sel got=%h exp=%h in=%h", out_data, exp_out, d); end
    end
  endtask

  task automatic test_rotate();
    int cyc;
    bit ev;
    logic [DW-1:0] want;
    reset_and_init(cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL rot_init_cycles got=%0d exp=16", cyc); end
    for (int k = 0; k < N_MAT; k++)
      for (int a = 0; a < 16; a++) cycle(0, '0, 0, '0, 1, k, a, a ^ k, ev);
    for (int b = 0; b < 8; b++) begin
      cycle(1, 8'h00, 1, '0, 0, 0, 0, 0, ev);
      want = (b < 4) ? 8'h10 : 8'h21;
      checks++; if (out_data !== want) begin failures++; $display("FAIL rotate_beat%0d got=%h exp=%h", b, out_data, want); end
    end
    // STATIC beats in between must not advance rotation.
    for (int b = 0; b < 3; b++) cycle(1, DW'($urandom), 0, 4'b0000, 0, 0, 0, 0, ev);
    for (int b = 0; b < 8; b++) begin
      cycle(1, DW'($urandom), 1, '0, 0, 0, 0, 0, ev);
      checks++; if (out_data !== exp_out) begin failures++; $display("FAIL rotate_resume%0d got=%h exp=%h", b, out_data, exp_out); end
    end
  endtask

  task automatic test_same_cycle();
    bit ev;
    cycle(1, 8'h55, 0, 4'b0000, 1, 0, 5, 0, ev);
    checks++; if (out_data !== 8'h55) begin failures++; $display("FAIL same_cycle_old got=%h exp=55", out_data); end
    cycle(1, 8'h55, 0, 4'b0000, 0, 0, 0, 0, ev);
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL same_cycle_new got=%h exp=00", out_data); end
  endtask

  task automatic test_random();
    bit ev;
    int bad_v, bad_d;
    bad_v = 0; bad_d = 0;
    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(0, 3) != 0, DW'($urandom), 1'($urandom_range(0, 1)), SW'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, 15), ev);
      checks++; if (out_valid !== ev) begin failures++; if (bad_v++ < 5) $display("FAIL rand_valid n=%0d got=%b exp=%b", n, out_valid, ev); end
      checks++; if (out_data !== exp_out) begin failures++; if (bad_d++ < 5) $display("FAIL rand_data n=%0d got=%h exp=%h", n, out_data, exp_out); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ev;
    cycle(1, 8'h12, 0, '0, 0, 0, 0, 0, ev);
    in_valid = 1'b1; in_data = 8'h77;
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL midstream_reset got=%b/%h exp=0/00", out_valid, out_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midstream_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_init_ready got=%b exp=0", in_ready); end
    reset_and_init(cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL mid_init_restart got=%0d exp=16", cyc); end
    cycle(1, 8'h55, 0, '0, 0, 0, 0, 0, ev);
    checks++; if (out_data !== 8'h55) begin failures++; $display("FAIL reinit_identity got=%h exp=55", out_data); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_identity();
    test_cfg_write();
    test_clamp();
    test_rotate();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
